// File: rtl/regbank_mp.sv
// Multi-port integer register bank with register 0 hardwired to zero,
// a per-register busy scoreboard and a sequential clear after reset. Optional same-cycle write bypass: REGBANK_BYPASS_EN.
module regbank_mp #(
  parameter int REGISTER_SIZE = 32,
  parameter int ADDRESS_SIZE  = 5,
  parameter int NUM_RD        = 2,
  parameter int NUM_WR        = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_RD*ADDRESS_SIZE-1:0]  addr_out,
  output logic [NUM_RD*REGISTER_SIZE-1:0] data_out,
  output logic [NUM_RD-1:0]               busy_out,
  input  logic [NUM_WR-1:0]               write,
  input  logic [NUM_WR*ADDRESS_SIZE-1:0]  addr_in,
  input  logic [NUM_WR*REGISTER_SIZE-1:0] data_in,
  input  logic                            issue,
  input  logic [ADDRESS_SIZE-1:0]         issue_addr,
  output logic                            ready
);

  localparam int DEPTH = 1 << ADDRESS_SIZE;
  localparam logic [ADDRESS_SIZE:0] LAST_IDX = (ADDRESS_SIZE+1)'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                   r_state;
  logic [ADDRESS_SIZE:0]    r_clear_idx;
  logic [REGISTER_SIZE-1:0] r_bank [DEPTH];
  logic [DEPTH-1:0]         r_busy;

  assign ready = (r_state == ST_READY) && !reset;

  // Storage is never reset in parallel; the CLEAR sequencer zeroes one entry per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_CLEAR) begin
        r_bank[r_clear_idx[ADDRESS_SIZE-1:0]] <= '0;
      end else begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (write[j] && (addr_in[j*ADDRESS_SIZE +: ADDRESS_SIZE] != '0))
            r_bank[addr_in[j*ADDRESS_SIZE +: ADDRESS_SIZE]] <= data_in[j*REGISTER_SIZE +: REGISTER_SIZE];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_CLEAR;
      r_clear_idx <= '0;
      r_busy      <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clear_idx <= r_clear_idx + 1'b1;
      if (r_clear_idx == LAST_IDX)
        r_state <= ST_READY;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (write[j])
          r_busy[addr_in[j*ADDRESS_SIZE +: ADDRESS_SIZE]] <= 1'b0;
      end
      // Issue is applied last so a new producer supersedes a completing write.
      if (issue && (issue_addr != '0))
        r_busy[issue_addr] <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDRESS_SIZE-1:0]  w_raddr;
      logic [REGISTER_SIZE-1:0] w_rdata;
      logic                     w_rbusy;

      assign w_raddr = addr_out[gi*ADDRESS_SIZE +: ADDRESS_SIZE];

      always_comb begin
        w_rdata = r_bank[w_raddr];
        w_rbusy = r_busy[w_raddr];
`ifdef REGBANK_BYPASS_EN
        for (int j = 0; j < NUM_WR; j++) begin
          if (write[j] && (addr_in[j*ADDRESS_SIZE +: ADDRESS_SIZE] == w_raddr)) begin
            w_rdata = data_in[j*REGISTER_SIZE +: REGISTER_SIZE];
            w_rbusy = 1'b0;
          end
        end
`endif
        if ((r_state != ST_READY) || (w_raddr == '0)) begin
          w_rdata = '0;
          w_rbusy = 1'b0;
        end
      end

      assign data_out[gi*REGISTER_SIZE +: REGISTER_SIZE] = w_rdata;
      assign busy_out[gi] = w_rbusy;
    end
  endgenerate

endmodule

// File: tb/tb_regbank_mp.sv
// Directed, table-driven bench for regbank_mp: sequential clear, writes,
// port priority, register 0 and the busy scoreboard.
module tb_regbank_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  addr_out;
  logic [63:0] data_out;
  logic [1:0]  busy_out;
  logic [1:0]  write;
  logic [9:0]  addr_in;
  logic [63:0] data_in;
  logic        issue;
  logic [4:0]  issue_addr;
  logic        ready;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regbank_mp dut (
    .clk(clk), .reset(reset), .addr_out(addr_out), .data_out(data_out),
    .busy_out(busy_out), .write(write), .addr_in(addr_in), .data_in(data_in),
    .issue(issue), .issue_addr(issue_addr), .ready(ready)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  ra0, ra1;
    logic [31:0] ed0, ed1;
    logic        eb0, eb1;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1, logic iss, logic [4:0] ia,
                              logic [4:0] ra0, logic [4:0] ra1, logic [31:0] ed0,
                              logic [31:0] ed1, logic eb0, logic eb1);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.iss = iss; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1;
    v.ed0 = ed0; v.ed1 = ed1; v.eb0 = eb0; v.eb1 = eb1;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle();
    write = 2'b00; addr_in = '0; data_in = '0; issue = 1'b0; issue_addr = '0;
  endtask

  // Counts negedges until ready rises; inputs optionally hammer writes/issues during CLEAR.
  task automatic count_clear(output int cnt, input bit noisy);
    cnt = 0;
    while (!ready && cnt < 100) begin
      if (noisy) begin
        write = 2'b11;
        addr_in = {5'($urandom_range(1, 31)), 5'($urandom_range(1, 31))};
        data_in = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        issue = 1'b1;
        issue_addr = 5'($urandom_range(1, 31));
      end
      @(negedge clk);
      cnt++;
    end
    idle();
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    addr_out = '0;
    idle();
    repeat (3) @(negedge clk);
    chk("ready_in_reset", {31'd0, ready}, 32'd0);
    reset = 1'b0;
    count_clear(cnt, 1'b0);
    chk("clear_cycles", cnt, 32'd32);
    $display("reset release: ready after %0d cycles", cnt);

    vecs[0] = mk(2'b01, 5'd3, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    vecs[1] = mk(2'b01, 5'd0, 32'h1234_5678, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    vecs[2] = mk(2'b11, 5'd7, 32'h1, 5'd7, 32'h2, 1'b0, 5'd0, 5'd7, 5'd3, 32'h2, 32'hDEAD_BEEF, 1'b0, 1'b0);
    vecs[3] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd7, 32'h0, 32'h2, 1'b1, 1'b0);
    vecs[4] = mk(2'b10, 5'd0, 32'h0, 5'd9, 32'hAAAA_5555, 1'b0, 5'd0, 5'd9, 5'd9, 32'hAAAA_5555, 32'hAAAA_5555, 1'b0, 1'b0);
    vecs[5] = mk(2'b01, 5'd9, 32'h1357_9BDF, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd3, 32'h1357_9BDF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    vecs[6] = mk(2'b11, 5'd5, 32'h55, 5'd6, 32'h66, 1'b1, 5'd5, 5'd5, 5'd6, 32'h55, 32'h66, 1'b1, 1'b0);
    vecs[7] = mk(2'b11, 5'd6, 32'h11, 5'd5, 32'h22, 1'b0, 5'd0, 5'd6, 5'd5, 32'h11, 32'h22, 1'b0, 1'b0);
    vecs[8] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd1, 32'h0, 32'h0, 1'b0, 1'b0);
    vecs[9] = mk(2'b01, 5'd31, 32'hFFFF_0000, 5'd31, 32'h1, 1'b0, 5'd0, 5'd31, 5'd9, 32'hFFFF_0000, 32'h1357_9BDF, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      write = vecs[i].we;
      addr_in = {vecs[i].wa1, vecs[i].wa0};
      data_in = {vecs[i].wd1, vecs[i].wd0};
      issue = vecs[i].iss;
      issue_addr = vecs[i].ia;
      addr_out = {vecs[i].ra1, vecs[i].ra0};
      @(negedge clk);
      idle();
      #1;
      chk($sformatf("v%0d_d0", i), data_out[31:0], vecs[i].ed0);
      chk($sformatf("v%0d_d1", i), data_out[63:32], vecs[i].ed1);
      chk($sformatf("v%0d_b0", i), {31'd0, busy_out[0]}, {31'd0, vecs[i].eb0});
      chk($sformatf("v%0d_b1", i), {31'd0, busy_out[1]}, {31'd0, vecs[i].eb1});
      $display("vec %0d: rd[%0d]=0x%08h busy=%0b rd[%0d]=0x%08h busy=%0b",
               i, vecs[i].ra0, data_out[31:0], busy_out[0], vecs[i].ra1, data_out[63:32], busy_out[1]);
    end

    // Same-cycle visibility of a write to a busy register.
    @(negedge clk);
    issue = 1'b1; issue_addr = 5'd12;
    @(negedge clk);
    idle();
    write = 2'b01; addr_in = {5'd0, 5'd3}; data_in = {32'h0, 32'hCAFE_F00D};
    addr_out = {5'd0, 5'd3};
    #1;
`ifdef REGBANK_BYPASS_EN
    chk("bypass_same_cycle", data_out[31:0], 32'hCAFE_F00D);
`else
    chk("no_bypass_same_cycle", data_out[31:0], 32'hDEAD_BEEF);
`endif
    @(negedge clk);
    write = 2'b10; addr_in = {5'd12, 5'd0}; data_in = {32'h0000_0C0C, 32'h0};
    addr_out = {5'd12, 5'd3};
    #1;
    chk("write_next_cycle", data_out[31:0], 32'hCAFE_F00D);
`ifdef REGBANK_BYPASS_EN
    chk("busy_bypass", {31'd0, busy_out[1]}, 32'd0);
`else
    chk("busy_same_cycle", {31'd0, busy_out[1]}, 32'd1);
`endif
    @(negedge clk);
    idle();
    #1;
    chk("busy_cleared", {31'd0, busy_out[1]}, 32'd0);
    chk("data_12", data_out[63:32], 32'h0000_0C0C);
    $display("bypass seq: rd[3]=0x%08h rd[12]=0x%08h", data_out[31:0], data_out[63:32]);

    // Fill the whole bank, then reset and interrupt the clear part-way.
    for (int a = 0; a < 32; a += 2) begin
      @(negedge clk);
      write = 2'b11; addr_in = {5'(a + 1), 5'(a)};
      data_in = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    end
    @(negedge clk);
    idle();
    addr_out = {5'd1, 5'd31};
    #1;
    chk("fill_31", data_out[31:0], 32'hFFFF_FFFF);
    chk("fill_1", data_out[63:32], 32'hFFFF_FFFF);
    reset = 1'b1;
    addr_out = {5'd31, 5'd5};
    @(negedge clk);
    chk("ready_low_reset", {31'd0, ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("clear_reads_zero", data_out[31:0], 32'd0);
    repeat (10) @(negedge clk);
    chk("ready_mid_clear", {31'd0, ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_clear(cnt, 1'b1);
    chk("reclear_cycles", cnt, 32'd32);
    $display("mid-clear reset: ready after %0d cycles", cnt);

    for (int a = 0; a < 32; a += 2) begin
      addr_out = {5'(a + 1), 5'(a)};
      #1;
      chk($sformatf("zero_%0d", a), data_out[31:0], 32'd0);
      chk($sformatf("zero_%0d", a + 1), data_out[63:32], 32'd0);
      chk($sformatf("busy_%0d_%0d", a, a + 1), {30'd0, busy_out}, 32'd0);
      $display("post-clear rd[%0d]=0x%08h rd[%0d]=0x%08h", a, data_out[31:0], a + 1, data_out[63:32]);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
